// File: rtl/dds_sweep_seq.sv
// dds_sweep_seq: BCD frequency-sweep sequencer for the DDS oscillator bus.
// Steps a BCD frequency from F0 by a fixed BCD increment, issuing one REQ
// strobe per point, holding each point for a programmable dwell, and
// reporting busy/done/overflow. The BCD add is digit-serial, LSD first.
module dds_sweep_seq #(
  parameter int C_DIGITs  = 8,
  parameter int C_CNT_W   = 12,
  parameter int C_DWELL_W = 24
) (
  input  logic                  CK_i,
  input  logic                  RST_i,
  input  logic                  START_i,
  input  logic                  ABORT_i,
  input  logic [4*C_DIGITs-1:0] CFG_F0_DECss_i,
  input  logic [4*C_DIGITs-1:0] CFG_STEP_DECss_i,
  input  logic [C_CNT_W-1:0]    CFG_STEPs_i,
  input  logic [C_DWELL_W-1:0]  CFG_DWELLs_i,
  input  logic [1:0]            CFG_MODEs_i,
  input  logic [3:0]            CFG_GAIN_SFTs_i,
  output logic [4*C_DIGITs-1:0] BUS_FREQ_DECss_o,
  output logic [1:0]            BUS_MODEs_o,
  output logic [3:0]            BUS_GAIN_SFTs_o,
  output logic                  REQ_o,
  output logic                  BUSY_o,
  output logic                  DONE_o,
  output logic                  OVF_o,
  output logic                  BAD_o,
  output logic [C_CNT_W-1:0]    IDXs_o
);

  localparam int FW    = 4 * C_DIGITs;
  localparam int DIG_W = (C_DIGITs > 1) ? $clog2(C_DIGITs) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DWELL,
    S_ADD,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [FW-1:0]        step_q;       // increment shadow; rotated one digit per ADD cycle
  logic [C_CNT_W-1:0]   n_q;          // last point index
  logic [C_DWELL_W-1:0] dwell_q;      // max(DWELL,1)
  logic [C_DWELL_W-1:0] dwell_cnt_q;
  logic [FW-1:0]        work_q;       // addend shifts out at the bottom, sum shifts in at the top
  logic                 carry_q;
  logic [DIG_W-1:0]     dig_q;

  logic                 start_valid;
  logic [4:0]           digit_raw;
  logic [3:0]           sum_digit;
  logic                 sum_carry;

  // True when every nibble of a BCD word is a legal decimal digit.
  function automatic logic bcd_valid(input logic [FW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < C_DIGITs; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // One BCD digit of the serial add plus the start-config validity check.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum_digit   = '0;
    sum_carry   = 1'b0;
    start_valid = bcd_valid(CFG_F0_DECss_i) && bcd_valid(CFG_STEP_DECss_i);
    digit_raw   = {1'b0, work_q[3:0]} + {1'b0, step_q[3:0]} + {4'd0, carry_q};
    if (digit_raw > 5'd9) begin
      sum_digit = 4'(digit_raw - 5'd10);
      sum_carry = 1'b1;
    end else begin
      sum_digit = digit_raw[3:0];
    end
  end

  // Sweep FSM with registered bus, strobe and status outputs.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      // NOTE: there is no memory array here, so every register is cheap to reset and all are.
      state_q          <= S_IDLE;
      step_q           <= '0;
      n_q              <= '0;
      dwell_q          <= '0;
      dwell_cnt_q      <= '0;
      work_q           <= '0;
      carry_q          <= 1'b0;
      dig_q            <= '0;
      BUS_FREQ_DECss_o <= '0;
      BUS_MODEs_o      <= '0;
      BUS_GAIN_SFTs_o  <= '0;
      REQ_o            <= 1'b0;
      BUSY_o           <= 1'b0;
      DONE_o           <= 1'b0;
      OVF_o            <= 1'b0;
      BAD_o            <= 1'b0;
      IDXs_o           <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      REQ_o  <= 1'b0;
      DONE_o <= 1'b0;
      BAD_o  <= 1'b0;

      if (state_q != S_IDLE && ABORT_i) begin
        // Abort outranks everything: strobes stay low, outputs and OVF hold.
        state_q <= S_IDLE;
        BUSY_o  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (START_i && !ABORT_i) begin
              if (start_valid) begin
                step_q           <= CFG_STEP_DECss_i;
                n_q              <= CFG_STEPs_i;
                dwell_q          <= (CFG_DWELLs_i == '0) ? C_DWELL_W'(1) : CFG_DWELLs_i;
                BUS_FREQ_DECss_o <= CFG_F0_DECss_i;
                BUS_MODEs_o      <= CFG_MODEs_i;
                BUS_GAIN_SFTs_o  <= CFG_GAIN_SFTs_i;
                IDXs_o           <= '0;
                OVF_o            <= 1'b0;
                REQ_o            <= 1'b1;
                BUSY_o           <= 1'b1;
                state_q          <= S_REQ;
              end else begin
                BAD_o <= 1'b1;
              end
            end
          end

          S_REQ: begin
            dwell_cnt_q <= dwell_q;
            state_q     <= S_DWELL;
          end

          S_DWELL: begin
            if (dwell_cnt_q == C_DWELL_W'(1)) begin
              if (IDXs_o == n_q) begin
                DONE_o  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                work_q  <= BUS_FREQ_DECss_o;
                carry_q <= 1'b0;
                dig_q   <= '0;
                state_q <= S_ADD;
              end
            end else begin
              dwell_cnt_q <= dwell_cnt_q - C_DWELL_W'(1);
            end
          end

          S_ADD: begin
            work_q  <= {sum_digit, work_q[FW-1:4]};
            step_q  <= {step_q[3:0], step_q[FW-1:4]};
            carry_q <= sum_carry;
            dig_q   <= dig_q + DIG_W'(1);
            if (dig_q == DIG_W'(C_DIGITs - 1)) begin
              if (sum_carry) begin
                // Sum does not fit: keep the last good frequency and finish.
                OVF_o   <= 1'b1;
                DONE_o  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                BUS_FREQ_DECss_o <= {sum_digit, work_q[FW-1:4]};
                IDXs_o           <= IDXs_o + C_CNT_W'(1);
                REQ_o            <= 1'b1;
                state_q          <= S_REQ;
              end
            end
          end

          S_DONE: begin
            BUSY_o  <= 1'b0;
            state_q <= S_IDLE;
          end

          default: begin
            BUSY_o  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_seq.sv
// tb_dds_sweep_seq: scoreboard bench for dds_sweep_seq. Each sweep pushes the
// expected REQ points and DONE event (with cycle numbers) from an integer
// decimal model; a negedge monitor pops and compares them as the DUT strobes.
module tb_dds_sweep_seq;

  localparam int DIG = 8;
  localparam int CW  = 12;
  localparam int DW  = 24;

  logic            CK_i = 1'b0;
  logic            RST_i;
  logic            START_i;
  logic            ABORT_i;
  logic [4*DIG-1:0] CFG_F0_DECss_i;
  logic [4*DIG-1:0] CFG_STEP_DECss_i;
  logic [CW-1:0]   CFG_STEPs_i;
  logic [DW-1:0]   CFG_DWELLs_i;
  logic [1:0]      CFG_MODEs_i;
  logic [3:0]      CFG_GAIN_SFTs_i;
  logic [4*DIG-1:0] BUS_FREQ_DECss_o;
  logic [1:0]      BUS_MODEs_o;
  logic [3:0]      BUS_GAIN_SFTs_o;
  logic            REQ_o;
  logic            BUSY_o;
  logic            DONE_o;
  logic            OVF_o;
  logic            BAD_o;
  logic [CW-1:0]   IDXs_o;

  dds_sweep_seq #(.C_DIGITs(DIG), .C_CNT_W(CW), .C_DWELL_W(DW)) dut (
    .CK_i             (CK_i),
    .RST_i            (RST_i),
    .START_i          (START_i),
    .ABORT_i          (ABORT_i),
    .CFG_F0_DECss_i   (CFG_F0_DECss_i),
    .CFG_STEP_DECss_i (CFG_STEP_DECss_i),
    .CFG_STEPs_i      (CFG_STEPs_i),
    .CFG_DWELLs_i     (CFG_DWELLs_i),
    .CFG_MODEs_i      (CFG_MODEs_i),
    .CFG_GAIN_SFTs_i  (CFG_GAIN_SFTs_i),
    .BUS_FREQ_DECss_o (BUS_FREQ_DECss_o),
    .BUS_MODEs_o      (BUS_MODEs_o),
    .BUS_GAIN_SFTs_o  (BUS_GAIN_SFTs_o),
    .REQ_o            (REQ_o),
    .BUSY_o           (BUSY_o),
    .DONE_o           (DONE_o),
    .OVF_o            (OVF_o),
    .BAD_o            (BAD_o),
    .IDXs_o           (IDXs_o)
  );

  always #5 CK_i = ~CK_i;

  // Cycle number: value k during the cycle following the k-th rising edge.
  int cyc = 0;
  always @(posedge CK_i) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [31:0]   freq;
    logic [CW-1:0] idx;
    logic [1:0]    mode;
    logic [3:0]    gain;
  } req_t;

  typedef struct {
    int   cyc;
    logic ovf;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];
  req_t  re;
  done_t de;

  int n_checks = 0;
  int n_errors = 0;

  int          c0;
  int          exp_done;
  logic [31:0] exp_freq;
  logic [CW-1:0] exp_idx;
  logic [31:0] prev_freq = '0;
  logic [31:0] held;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic longint bcd2int(input logic [31:0] b);
    longint v = 0;
    for (int i = DIG - 1; i >= 0; i--) v = v * 10 + longint'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [31:0] int2bcd(input longint v);
    logic [31:0] r = '0;
    longint      t = v;
    for (int i = 0; i < DIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CK_i) begin
    if (REQ_o) begin
      if (req_q.size() == 0) begin
        check("req_unexpected", 64'(REQ_o), 64'd0);
      end else begin
        re = req_q.pop_front();
        check("req_cycle", 64'(cyc), 64'(re.cyc));
        check("req_freq", 64'(BUS_FREQ_DECss_o), 64'(re.freq));
        check("req_idx", 64'(IDXs_o), 64'(re.idx));
        check("req_mode", 64'(BUS_MODEs_o), 64'(re.mode));
        check("req_gain", 64'(BUS_GAIN_SFTs_o), 64'(re.gain));
      end
    end
    if (DONE_o) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 64'(DONE_o), 64'd0);
      end else begin
        de = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(de.cyc));
        check("done_ovf", 64'(OVF_o), 64'(de.ovf));
      end
    end
    // Frequency may only change together with a REQ strobe (no partial sums).
    if (BUS_FREQ_DECss_o !== prev_freq && RST_i !== 1'b1)
      check("freq_change_without_req", 64'(REQ_o), 64'd1);
    prev_freq = BUS_FREQ_DECss_o;
  end

  function automatic logic [63:0] all_outputs();
    return 64'({BUS_FREQ_DECss_o, BUS_MODEs_o, BUS_GAIN_SFTs_o, REQ_o, BUSY_o,
                DONE_o, OVF_o, BAD_o, IDXs_o});
  endfunction

  // Start a sweep in cycle c0 and push its expected REQ points and DONE event.
  task automatic run_sweep(input logic [31:0] f0, input logic [31:0] st, input int n,
                           input int d, input logic [1:0] md, input logic [3:0] gn);
    longint fi;
    longint si;
    int     dd;
    int     r;
    @(negedge CK_i);
    CFG_F0_DECss_i   = f0;
    CFG_STEP_DECss_i = st;
    CFG_STEPs_i      = CW'(n);
    CFG_DWELLs_i     = DW'(d);
    CFG_MODEs_i      = md;
    CFG_GAIN_SFTs_i  = gn;
    ABORT_i          = 1'b0;
    START_i          = 1'b1;
    c0 = cyc;
    dd = (d == 0) ? 1 : d;
    fi = bcd2int(f0);
    si = bcd2int(st);
    r  = c0 + 1;
    for (int k = 0; k <= n; k++) begin
      req_q.push_back('{cyc: r, freq: int2bcd(fi), idx: CW'(k), mode: md, gain: gn});
      exp_freq = int2bcd(fi);
      exp_idx  = CW'(k);
      if (k == n) begin
        exp_done = r + dd + 1;
        done_q.push_back('{cyc: exp_done, ovf: 1'b0});
      end else if (fi + si > 64'd99999999) begin
        exp_done = r + dd + 9;
        done_q.push_back('{cyc: exp_done, ovf: 1'b1});
        break;
      end else begin
        fi = fi + si;
        r  = r + dd + 9;
      end
    end
    @(negedge CK_i);
    START_i = 1'b0;
    // Scramble config mid-sweep; the shadow registers must make this harmless.
    CFG_F0_DECss_i   = $urandom;
    CFG_STEP_DECss_i = $urandom;
    CFG_STEPs_i      = CW'($urandom);
    CFG_DWELLs_i     = DW'($urandom_range(0, 3));
    CFG_MODEs_i      = 2'($urandom);
    CFG_GAIN_SFTs_i  = 4'($urandom);
  endtask

  // Wait (bounded) for BUSY_o to fall, then confirm the scoreboard drained.
  task automatic wait_idle(input bit check_cycle);
    int i;
    for (i = 0; i < 5000; i++) begin
      if (!BUSY_o) break;
      @(negedge CK_i);
    end
    if (i == 5000) check("busy_timeout", 64'(BUSY_o), 64'd0);
    else if (check_cycle) check("busy_fall_cycle", 64'(cyc), 64'(exp_done + 1));
    check("req_pending", 64'(req_q.size()), 64'd0);
    check("done_pending", 64'(done_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held 3 cycles with a valid START present: nothing may start.
    RST_i            = 1'b1;
    START_i          = 1'b1;
    ABORT_i          = 1'b0;
    CFG_F0_DECss_i   = 32'h0000_1000;
    CFG_STEP_DECss_i = 32'h0000_0250;
    CFG_STEPs_i      = CW'(3);
    CFG_DWELLs_i     = DW'(4);
    CFG_MODEs_i      = 2'd1;
    CFG_GAIN_SFTs_i  = 4'd2;
    repeat (3) @(negedge CK_i);
    check("reset_outputs", all_outputs(), 64'd0);
    RST_i   = 1'b0;
    START_i = 1'b0;
    @(negedge CK_i);
    check("post_reset_idle", all_outputs(), 64'd0);

    // Basic sweep: REQ at 1,14,27,40; DONE at 45; idle from 46.
    run_sweep(32'h0000_1000, 32'h0000_0250, 3, 4, 2'd2, 4'd5);
    check("busy_after_start", 64'(BUSY_o), 64'd1);
    wait_idle(1'b1);
    check("hold_freq_sweep", 64'(BUS_FREQ_DECss_o), 64'h0000_1750);
    check("hold_idx_sweep", 64'(IDXs_o), 64'(exp_idx));

    // Carry ripples through five digits.
    run_sweep(32'h0009_9999, 32'h0000_0001, 1, 1, 2'd0, 4'd0);
    wait_idle(1'b1);
    check("hold_freq_carry", 64'(BUS_FREQ_DECss_o), 64'h0010_0000);

    // Overflow on the first add: one REQ, OVF set, frequency held.
    run_sweep(32'h9999_9990, 32'h0000_0020, 5, 2, 2'd3, 4'd15);
    wait_idle(1'b1);
    check("ovf_sticky", 64'(OVF_o), 64'd1);
    check("hold_freq_ovf", 64'(BUS_FREQ_DECss_o), 64'h9999_9990);
    check("hold_idx_ovf", 64'(IDXs_o), 64'd0);

    // N=0 with DWELL=0 (treated as 1); the accepted start clears OVF.
    run_sweep(32'h1234_5678, 32'h1111_1111, 0, 0, 2'd1, 4'd7);
    check("ovf_cleared", 64'(OVF_o), 64'd0);
    wait_idle(1'b1);

    // Abort in dwell cycle 3 of a D=100 point; START while busy is ignored.
    run_sweep(32'h0000_0005, 32'h0000_0001, 2, 100, 2'd0, 4'd3);
    @(negedge CK_i);
    CFG_F0_DECss_i = 32'h0000_0777;
    START_i = 1'b1;
    @(negedge CK_i);
    START_i = 1'b0;
    @(negedge CK_i);
    ABORT_i = 1'b1;
    @(negedge CK_i);
    ABORT_i = 1'b0;
    check("abort_busy", 64'(BUSY_o), 64'd0);
    check("abort_hold_freq", 64'(BUS_FREQ_DECss_o), 64'h0000_0005);
    check("abort_hold_idx", 64'(IDXs_o), 64'd0);
    req_q.delete();
    done_q.delete();
    repeat (10) @(negedge CK_i);
    check("abort_still_idle", 64'(BUSY_o), 64'd0);
    run_sweep(32'h0000_0005, 32'h0000_0001, 1, 1, 2'd0, 4'd3);
    wait_idle(1'b1);
    check("restart_final_freq", 64'(BUS_FREQ_DECss_o), 64'h0000_0006);

    // Invalid BCD digits are rejected with a BAD pulse and nothing else.
    @(negedge CK_i);
    held             = BUS_FREQ_DECss_o;
    CFG_F0_DECss_i   = 32'h0000_A000;
    CFG_STEP_DECss_i = 32'h0000_0001;
    CFG_STEPs_i      = CW'(1);
    CFG_DWELLs_i     = DW'(1);
    START_i          = 1'b1;
    @(negedge CK_i);
    START_i = 1'b0;
    check("bad_f0_pulse", 64'(BAD_o), 64'd1);
    check("bad_f0_busy", 64'(BUSY_o), 64'd0);
    check("bad_f0_hold", 64'(BUS_FREQ_DECss_o), 64'(held));
    @(negedge CK_i);
    check("bad_one_cycle", 64'(BAD_o), 64'd0);
    CFG_F0_DECss_i   = 32'h0000_1000;
    CFG_STEP_DECss_i = 32'h0000_000F;
    START_i          = 1'b1;
    @(negedge CK_i);
    START_i = 1'b0;
    check("bad_step_pulse", 64'(BAD_o), 64'd1);
    @(negedge CK_i);
    // START and ABORT together in IDLE: abort wins, no BAD, no start.
    CFG_STEP_DECss_i = 32'h0000_0001;
    START_i          = 1'b1;
    ABORT_i          = 1'b1;
    @(negedge CK_i);
    START_i = 1'b0;
    ABORT_i = 1'b0;
    check("start_abort_bad", 64'(BAD_o), 64'd0);
    check("start_abort_busy", 64'(BUSY_o), 64'd0);
    repeat (3) @(negedge CK_i);

    // Reset mid-sweep: idle and cleared next cycle, no DONE afterwards.
    run_sweep(32'h0000_0001, 32'h0000_0001, 4, 20, 2'd2, 4'd9);
    @(negedge CK_i);
    RST_i = 1'b1;
    @(negedge CK_i);
    check("midsweep_reset_outputs", all_outputs(), 64'd0);
    req_q.delete();
    done_q.delete();
    @(negedge CK_i);
    RST_i = 1'b0;
    repeat (30) @(negedge CK_i);
    check("midsweep_reset_idle", 64'(BUSY_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
